// File: rtl/map_query.sv
// map_query: read-side client of the tile map ROM.
// Answers POINT (single tile) and SPAN (set-tile count between two columns)
// queries over valid/ready request and response channels.
module map_query #(
    parameter int ROW_AW = 5,
    parameter int ROW_W  = 32,
    parameter int CNT_W  = 6,
    localparam int CW    = $clog2(ROW_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [ROW_AW-1:0] req_row,
    input  logic [CW-1:0]     req_col0,
    input  logic [CW-1:0]     req_col1,
    output logic [ROW_AW-1:0] map_addr,
    input  logic [ROW_W-1:0]  map_bits,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [CNT_W-1:0]  rsp_count
);

    typedef enum logic [1:0] {IDLE, FETCH, SCAN, RESP} state_t;

    state_t             state, state_nxt;
    logic               op_span;
    logic [CW-1:0]      lo, hi, col;
    logic [ROW_W-1:0]   row_reg;
    logic [CNT_W-1:0]   count;
    logic               fetch_bit, scan_bit;
    logic [CNT_W-1:0]   scan_sum;

    // Column c lives at bit ROW_W-1-c (column 0 is the MSB).
    always_comb begin
        fetch_bit = map_bits[CW'(ROW_W-1) - lo];
        scan_bit  = row_reg[CW'(ROW_W-1) - col];
        scan_sum  = count + CNT_W'(scan_bit);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && !reset) state_nxt = FETCH;
            end
            FETCH: state_nxt = op_span ? SCAN : RESP;
            SCAN: begin
                if (col == hi) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: request capture, row fetch, column scan, result registers.
    // The column counter is compared against hi before incrementing so a
    // full-row span ends at the last column without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            map_addr  <= '0;
            rsp_hit   <= 1'b0;
            rsp_count <= '0;
            op_span   <= 1'b0;
            lo        <= '0;
            hi        <= '0;
            col       <= '0;
            count     <= '0;
            row_reg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_span  <= req_op;
                        map_addr <= req_row;
                        if (req_op && (req_col1 < req_col0)) begin
                            lo <= req_col1;
                            hi <= req_col0;
                        end else begin
                            lo <= req_col0;
                            hi <= req_col1;
                        end
                    end
                end
                FETCH: begin
                    row_reg <= map_bits;
                    if (!op_span) begin
                        rsp_hit   <= fetch_bit;
                        rsp_count <= CNT_W'(fetch_bit);
                    end else begin
                        col   <= lo;
                        count <= '0;
                    end
                end
                SCAN: begin
                    if (col == hi) begin
                        rsp_count <= scan_sum;
                        rsp_hit   <= (scan_sum != '0);
                    end else begin
                        count <= scan_sum;
                        col   <= col + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_map_query.sv
// tb_map_query: table-driven directed vectors, hand-written backpressure and
// reset sequences, and a randomized stream checked against a mask/popcount model.
module tb_map_query;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [4:0]  req_row;
    logic [4:0]  req_col0;
    logic [4:0]  req_col1;
    logic [4:0]  map_addr;
    logic [31:0] map_bits;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [5:0]  rsp_count;

    logic [31:0] rom [32];
    assign map_bits = rom[map_addr];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    map_query #(.ROW_AW(5), .ROW_W(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_row(req_row), .req_col0(req_col0), .req_col1(req_col1),
        .map_addr(map_addr), .map_bits(map_bits),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hit(rsp_hit), .rsp_count(rsp_count)
    );

    typedef struct {
        logic       op;
        logic [4:0] row;
        logic [4:0] c0;
        logic [4:0] c1;
        logic       hit;
        logic [5:0] cnt;
        int         lat;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: popcount of the row masked to columns lo..hi.
    function automatic void ref_q(input logic op, input logic [4:0] row,
                                  input logic [4:0] c0, input logic [4:0] c1,
                                  output logic hit, output logic [5:0] cnt);
        int lo, hi;
        logic [31:0] mask;
        lo = op ? ((c0 < c1) ? c0 : c1) : c0;
        hi = op ? ((c0 < c1) ? c1 : c0) : c0;
        mask = (32'hFFFF_FFFF >> lo) & (32'hFFFF_FFFF << (31 - hi));
        cnt = 6'($countones(rom[row] & mask));
        hit = (cnt != 0);
    endfunction

    // Present a request and return one edge after it was accepted.
    task automatic send(input logic op, input logic [4:0] row,
                        input logic [4:0] c0, input logic [4:0] c1);
        bit acc = 0;
        req_valid = 1'b1; req_op = op; req_row = row; req_col0 = c0; req_col1 = c1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                acc = 1;
                break;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        // scramble fields after accept; the DUT must ignore them
        req_op = 1'($urandom); req_row = 5'($urandom);
        req_col0 = 5'($urandom); req_col1 = 5'($urandom);
        chk("accept", acc, 1);
    endtask

    // Count edges from the accept edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        rsp_ready = 1'b1;
        send(v.op, v.row, v.c0, v.c1);
        chk({tag, " map_addr"}, map_addr, v.row);
        wait_rsp(lat);
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " hit"}, rsp_hit, v.hit);
        chk({tag, " count"}, rsp_count, v.cnt);
        @(posedge clk); #1;
        chk({tag, " valid_drop"}, rsp_valid, 0);
    endtask

    initial begin
        int lat;
        bit seen;
        logic eh;
        logic [5:0] ec;

        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_op = 1'b0; req_row = '0; req_col0 = '0; req_col1 = '0;
        for (int i = 0; i < 32; i++) rom[i] = $urandom;
        rom[3] = 32'h8000_0001;
        rom[5] = 32'hFFFF_FFFF;
        rom[7] = 32'h0F00_0000;

        vecs[0] = '{1'b0, 5'd3,  5'd0,  5'd0,  1'b1, 6'd1,  2};
        vecs[1] = '{1'b0, 5'd3,  5'd1,  5'd0,  1'b0, 6'd0,  2};
        vecs[2] = '{1'b0, 5'd3,  5'd31, 5'd0,  1'b1, 6'd1,  2};
        vecs[3] = '{1'b1, 5'd5,  5'd0,  5'd31, 1'b1, 6'd32, 34};
        vecs[4] = '{1'b1, 5'd7,  5'd10, 5'd2,  1'b1, 6'd4,  11};
        vecs[5] = '{1'b1, 5'd7,  5'd8,  5'd31, 1'b0, 6'd0,  26};
        vecs[6] = '{1'b1, 5'd7,  5'd5,  5'd5,  1'b1, 6'd1,  3};
        vecs[7] = '{1'b1, 5'd7,  5'd3,  5'd3,  1'b0, 6'd0,  3};
        vecs[8] = '{1'b1, 5'd3,  5'd31, 5'd0,  1'b1, 6'd2,  34};
        vecs[9] = '{1'b1, 5'd5,  5'd17, 5'd17, 1'b1, 6'd1,  3};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready", req_ready, 0);
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst map_addr", map_addr, 0);
        chk("rst rsp_hit", rsp_hit, 0);
        chk("rst rsp_count", rsp_count, 0);
        reset = 1'b0;
        #1;
        chk("idle req_ready", req_ready, 1);

        // directed table
        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // backpressure with a pending request held high
        rsp_ready = 1'b0;
        send(1'b0, 5'd3, 5'd0, 5'd0);
        wait_rsp(lat);
        chk("bp latency", lat, 2);
        req_valid = 1'b1; req_op = 1'b0; req_row = 5'd5; req_col0 = 5'd3; req_col1 = 5'd0;
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", rsp_valid, 1);
            chk("bp hit", rsp_hit, 1);
            chk("bp count", rsp_count, 1);
            chk("bp req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        chk("bp still valid", rsp_valid, 1);
        @(posedge clk); #1;
        chk("bp handoff valid", rsp_valid, 0);
        chk("bp handoff ready", req_ready, 1);
        chk("bp no early accept", map_addr, 3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp next addr", map_addr, 5);
        chk("bp next busy", req_ready, 0);
        wait_rsp(lat);
        chk("bp next latency", lat, 2);
        chk("bp next hit", rsp_hit, 1);
        chk("bp next count", rsp_count, 1);
        @(posedge clk); #1;

        // reset in the middle of a span scan
        send(1'b1, 5'd5, 5'd0, 5'd31);
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid rst valid", rsp_valid, 0);
        chk("mid rst addr", map_addr, 0);
        chk("mid rst ready", req_ready, 0);
        chk("mid rst count", rsp_count, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen = 1;
            @(posedge clk); #1;
        end
        chk("mid rst no rsp", seen, 0);
        chk("mid rst addr hold", map_addr, 0);
        run_vec('{1'b0, 5'd7, 5'd4, 5'd0, 1'b1, 6'd1, 2}, "post rst");

        // randomized stream with random response backpressure
        for (int q = 0; q < 40; q++) begin
            logic op;
            logic [4:0] row, c0, c1;
            bit done;
            int expl;
            op = 1'($urandom); row = 5'($urandom);
            c0 = 5'($urandom); c1 = 5'($urandom);
            if (q % 8 == 0) rom[row] = $urandom;
            ref_q(op, row, c0, c1, eh, ec);
            expl = op ? 2 + ((c0 < c1) ? c1 - c0 : c0 - c1) + 1 : 2;
            rsp_ready = 1'($urandom);
            send(op, row, c0, c1);
            lat = 1;
            seen = 0;
            done = 0;
            for (int cyc = 0; cyc < 200; cyc++) begin
                rsp_ready = 1'($urandom);
                if (rsp_valid && !seen) begin
                    seen = 1;
                    chk($sformatf("rnd%0d latency", q), lat, expl);
                end
                if (rsp_valid && rsp_ready) begin
                    chk($sformatf("rnd%0d hit", q), rsp_hit, eh);
                    chk($sformatf("rnd%0d count", q), rsp_count, ec);
                    @(posedge clk); #1;
                    done = 1;
                    break;
                end
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("rnd%0d delivered", q), done, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
